latency_ctrl: RTL and testbench
===============================

Name: latency_ctrl

Overview:
- Flow-control wrapper around a fixed-latency datapath, such as a delay line or a pipelined decoder stage with no stall input.
- Accepts valid/ready beats from upstream and launches them into the external datapath.
- Tracks in-flight beats with a token shift register and catches returning data in an output FIFO.
- Throttles acceptance with a credit count, so a stalled downstream never overflows the FIFO.
- Provides a flush/drain sequence used before decoder reconfiguration.

Parameters:
- DATA_WIDTH, 8: width of data beats.
- LATENCY, 4: datapath latency in clock cycles; must be >= 1.
- FIFO_DEPTH, 8: output FIFO entries; must be >= 2. Sustained 1 beat/cycle requires FIFO_DEPTH >= LATENCY+2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  upstream ready.
- i_data  in  DATA_WIDTH  upstream data.
- o_dp_launch  out  1  launch strobe to the datapath.
- o_dp_data  out  DATA_WIDTH  data to the datapath.
- i_dp_data  in  DATA_WIDTH  datapath output; valid exactly LATENCY cycles after launch.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  DATA_WIDTH  downstream data.
- i_flush  in  1  flush request pulse.
- o_flush_done  out  1  one-cycle pulse when the flush completes.
- o_busy  out  1  high when any beat is in flight or buffered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: o_ready=0, o_dp_launch=0, o_dp_data=0, o_valid=0, o_data=0, o_flush_done=0, o_busy=0. Token shift register, inflight counter and FIFO are all cleared; state = RUN.
- Reset mid-operation: all in-flight and buffered beats are discarded. Datapath data returning after reset is ignored, because its tokens were cleared.
- Acceptance:
  - fire = i_valid & o_ready.
  - o_dp_launch = fire (combinational); o_dp_data = i_data.
  - o_dp_data is not gated: when o_dp_launch=0 it carries don't-care data.
- Token tracking:
  - tok[LATENCY-1:0] shifts every cycle, with tok[0] <= fire.
  - ret = tok[LATENCY-1]. When ret=1, i_dp_data is pushed into the FIFO in that cycle.
  - inflight counter, width clog2(LATENCY+1): +1 on fire, -1 on ret, unchanged when both occur in the same cycle.
- Credits:
  - credit = FIFO_DEPTH - fifo_count - inflight.
  - A same-cycle pop is not credited, which keeps o_ready free of a combinational path from i_ready.
  - o_ready = (state==RUN) & (credit != 0).
  - Invariant: fifo_count + inflight <= FIFO_DEPTH, so a push never meets a full FIFO.
- Output FIFO:
  - First-word fall-through: o_valid = !empty, o_data = head entry.
  - Pop when o_valid & i_ready.
  - Push and pop may occur in the same cycle; the count is unchanged.
  - Push into an empty FIFO: o_valid rises on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; non-power-of-2 depths are supported.
- State machine (RUN, DRAIN, DONE):
  - RUN: on i_flush go to DRAIN. The beat in the same cycle is still accepted, since o_ready is derived from the registered state.
  - DRAIN: o_ready=0. When inflight==0 and the FIFO is empty, go to DONE. A beat popped downstream in a cycle counts toward empty on the following cycle.
  - DONE: o_flush_done=1 for one cycle, then return to RUN.
  - i_flush is ignored in DRAIN and DONE.
- Status: o_busy = (inflight != 0) | !empty.
- Latency: a beat accepted at cycle t is pushed to the FIFO at t+LATENCY and first seen on o_valid at t+LATENCY+1 if the FIFO was empty.

Decomposition:
- Shared package (decoder common): the state encoding RUN/DRAIN/DONE and a clog2 function for the counter and pointer widths.
- One sub-module: latency_ctrl_fifo, a synchronous FWFT FIFO with parameters DATA_WIDTH and FIFO_DEPTH. It provides push, pop, data, empty, full and count, and resets synchronously on active-high rst.
- The token shift register, credit logic and FSM stay in latency_ctrl.

Test Plan:
- Streaming: LATENCY=4, FIFO_DEPTH=8, i_ready=1, 20 back-to-back beats 0x00..0x13. Required: o_ready stays 1; the datapath model returns each beat 4 cycles after launch; outputs appear in order, 1 per cycle, each exactly 5 cycles after its acceptance.
- Backpressure: i_ready=0 while sending 12 beats. Required: exactly 8 beats accepted and o_ready=0 after that. Then i_ready=1: all 8 delivered in order; o_ready returns to 1 one cycle after the first pop.
- Minimum latency: LATENCY=1, FIFO_DEPTH=3, streaming with i_ready=1. Required: sustained 1 beat/cycle and no FIFO overflow.
- Flush: flush with 3 beats in flight and 2 buffered, i_ready=1. Required: o_ready=0 from the next cycle; all 5 beats delivered; o_flush_done pulses once 1 cycle after the FIFO empties; o_ready then returns.
- Reset: rst with 4 beats in flight. Required: outputs are 0 on the next cycle; late datapath returns produce no o_valid; o_busy=0.
- Randomized i_valid/i_ready over 1000 cycles, with i_flush pulses also asserted during DRAIN. Required: scoreboard order matches, no push on a full FIFO, and fifo_count + inflight <= 8 at every cycle.

Source files
------------

// File: rtl/latency_ctrl_pkg.sv
// Shared decoder definitions: flush state encoding and width helper.
package latency_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/latency_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; depth need not be a power of two.
module latency_ctrl_fifo
    import latency_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                pop,
    output logic [DATA_WIDTH-1:0]               pop_data,
    output logic                                empty,
    output logic                                full,
    output logic [clog2(FIFO_DEPTH + 1)-1:0]    count
);

    localparam int unsigned PW = clog2(FIFO_DEPTH);
    localparam int unsigned CW = clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(FIFO_DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

    // Storage is cleared too so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/latency_ctrl.sv
// Valid/ready wrapper around a fixed-latency datapath with credit throttling,
// in-flight token tracking, an output FIFO and a flush/drain sequence.
module latency_ctrl
    import latency_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_dp_launch,
    output logic [DATA_WIDTH-1:0] o_dp_data,
    input  logic [DATA_WIDTH-1:0] i_dp_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic                  o_busy
);

    localparam int unsigned IW = clog2(LATENCY + 1);
    localparam int unsigned CW = clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = clog2(FIFO_DEPTH + LATENCY + 1);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [LATENCY-1:0] tok;
    logic [LATENCY-1:0] tok_next;
    logic [IW-1:0]      inflight;
    logic [OW-1:0]      occupancy;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               has_credit;
    logic               fire;
    logic               ret;
    logic               pop;

    // Credit ignores a same-cycle pop so o_ready has no path from i_ready.
    assign occupancy  = OW'(fifo_count) + OW'(inflight);
    assign has_credit = ~fifo_full & (occupancy < OW'(FIFO_DEPTH));
    // Held low during reset so nothing is launched while state is cleared.
    assign o_ready    = ~rst & (state == ST_RUN) & has_credit;

    assign fire         = i_valid & o_ready;
    assign o_dp_launch  = fire;
    assign o_dp_data    = i_data;
    assign ret          = tok[LATENCY-1];
    assign o_valid      = ~fifo_empty;
    assign pop          = o_valid & i_ready;
    assign o_flush_done = (state == ST_DONE);
    assign o_busy       = (inflight != '0) | ~fifo_empty;

    always_comb begin
        tok_next    = '0;
        tok_next[0] = fire;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tok_next[i] = tok[i-1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (i_flush) state_next = ST_DRAIN;
            ST_DRAIN: if ((inflight == '0) && fifo_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok      <= '0;
            inflight <= '0;
            state    <= ST_RUN;
        end else begin
            tok   <= tok_next;
            state <= state_next;
            case ({fire, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    latency_ctrl_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret),
        .push_data (i_dp_data),
        .pop       (pop),
        .pop_data  (o_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_latency_ctrl.sv
// Directed/table-driven bench for latency_ctrl: LATENCY=4/DEPTH=8 and LATENCY=1/DEPTH=3.
module tb_latency_ctrl;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] cyc;
    } beat_t;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       flush;
        logic       e_ready;
        logic       e_launch;
        logic       e_valid;
        logic       chk_data;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    // Instance A: LATENCY=4, FIFO_DEPTH=8
    logic       a_valid = 1'b0, a_ready = 1'b0, a_flush = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_o_ready, a_launch, a_o_valid, a_fd, a_busy;
    logic [7:0] a_dp_out, a_dp_in, a_o_data;
    logic [31:0] pipe_a = '0;

    // Instance B: LATENCY=1, FIFO_DEPTH=3
    logic       b_valid = 1'b0, b_ready = 1'b0, b_flush = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_o_ready, b_launch, b_o_valid, b_fd, b_busy;
    logic [7:0] b_dp_out, b_dp_in, b_o_data;
    logic [7:0] pipe_b = '0;

    beat_t exp_a[$];
    beat_t exp_b[$];
    bit    timing_a = 1'b0, timing_b = 1'b0;
    int    deliv_a = 0, deliv_b = 0;

    vec_t vecs[12];

    latency_ctrl #(.DATA_WIDTH(8), .LATENCY(4), .FIFO_DEPTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_o_ready), .i_data(a_data),
        .o_dp_launch(a_launch), .o_dp_data(a_dp_out), .i_dp_data(a_dp_in),
        .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data),
        .i_flush(a_flush), .o_flush_done(a_fd), .o_busy(a_busy)
    );

    latency_ctrl #(.DATA_WIDTH(8), .LATENCY(1), .FIFO_DEPTH(3)) u_dut_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_o_ready), .i_data(b_data),
        .o_dp_launch(b_launch), .o_dp_data(b_dp_out), .i_dp_data(b_dp_in),
        .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data),
        .i_flush(b_flush), .o_flush_done(b_fd), .o_busy(b_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath models: fixed delay, result = data ^ 0x5A; idle slots carry 0xEE.
    always @(posedge clk) begin
        pipe_a <= {pipe_a[23:0], (a_launch ? (a_dp_out ^ 8'h5A) : 8'hEE)};
        pipe_b <= b_launch ? (b_dp_out ^ 8'h5A) : 8'hEE;
    end
    assign a_dp_in = pipe_a[31:24];
    assign b_dp_in = pipe_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input bit sel_b, input int unsigned limit);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while ((sel_b ? b_busy : a_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, sel_b ? b_busy : a_busy, 0);
        next_cycle();
    endtask

    always @(negedge clk) begin : mon_a
        beat_t b;
        if (rst) begin
            exp_a.delete();
        end else begin
            check("a_launch", a_launch, a_valid & a_o_ready);
            check("a_dp_data", a_dp_out, a_data);
            check("a_occupancy", exp_a.size() <= 8, 1);
            check("a_busy", a_busy, exp_a.size() != 0);
            if (a_o_valid && a_ready) begin
                check("a_sb_nonempty", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    b = exp_a.pop_front();
                    check("a_data_order", a_o_data, b.data ^ 8'h5A);
                    if (timing_a) check("a_latency", cyc - b.cyc, 5);
                end
                deliv_a++;
            end
            if (a_valid && a_o_ready) exp_a.push_back('{data: a_data, cyc: cyc});
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t b;
        if (rst) begin
            exp_b.delete();
        end else begin
            check("b_launch", b_launch, b_valid & b_o_ready);
            check("b_occupancy", exp_b.size() <= 3, 1);
            check("b_busy", b_busy, exp_b.size() != 0);
            if (b_o_valid && b_ready) begin
                check("b_sb_nonempty", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    b = exp_b.pop_front();
                    check("b_data_order", b_o_data, b.data ^ 8'h5A);
                    if (timing_b) check("b_latency", cyc - b.cyc, 2);
                end
                deliv_b++;
            end
            if (b_valid && b_o_ready) exp_b.push_back('{data: b_data, cyc: cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;

        //          rst   vld   data   rdy   fl    rdy   lnch  vld   chkd  data   busy  fd
        vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (2) next_cycle();

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            a_valid = vecs[i].valid;
            a_data = vecs[i].data;
            a_ready = vecs[i].rdy;
            a_flush = vecs[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), a_o_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_launch", i), a_launch, vecs[i].e_launch);
            check($sformatf("vec%0d_valid", i), a_o_valid, vecs[i].e_valid);
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), a_o_data, vecs[i].e_data);
            check($sformatf("vec%0d_busy", i), a_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_flush_done", i), a_fd, vecs[i].e_fd);
            next_cycle();
        end
        a_valid = 1'b0;
        a_flush = 1'b0;
        wait_idle("table_idle", 1'b0, 50);

        // Streaming, 20 back-to-back beats with 5-cycle acceptance-to-output latency.
        base = deliv_a;
        timing_a = 1'b1;
        a_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_valid = 1'b1;
            a_data = 8'(k);
            @(negedge clk);
            check("stream_ready", a_o_ready, 1);
            next_cycle();
        end
        a_valid = 1'b0;
        wait_idle("stream_idle", 1'b0, 50);
        timing_a = 1'b0;
        check("stream_count", deliv_a - base, 20);

        // Backpressure: only 8 of 12 offered beats fit.
        base = deliv_a;
        acc = 0;
        a_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            a_valid = 1'b1;
            a_data = 8'(8'h30 + k);
            @(negedge clk);
            if (a_o_ready) acc++;
            next_cycle();
        end
        a_valid = 1'b0;
        check("bp_accepted", acc, 8);
        repeat (2) next_cycle();
        @(negedge clk);
        check("bp_ready_low", a_o_ready, 0);
        next_cycle();
        a_ready = 1'b1;
        @(negedge clk);
        check("bp_first_pop_valid", a_o_valid, 1);
        check("bp_ready_during_pop", a_o_ready, 0);
        next_cycle();
        @(negedge clk);
        check("bp_ready_after_pop", a_o_ready, 1);
        next_cycle();
        wait_idle("bp_idle", 1'b0, 50);
        check("bp_count", deliv_a - base, 8);

        // Minimum latency on instance B: sustained 1 beat/cycle.
        base = deliv_b;
        timing_b = 1'b1;
        b_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b_valid = 1'b1;
            b_data = 8'(8'h80 + k);
            @(negedge clk);
            check("minlat_ready", b_o_ready, 1);
            next_cycle();
        end
        b_valid = 1'b0;
        wait_idle("minlat_idle", 1'b1, 50);
        timing_b = 1'b0;
        check("minlat_count", deliv_b - base, 20);

        // Flush with 2 beats buffered and 3 in flight; second flush pulse lands in DRAIN.
        base = deliv_a;
        a_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_valid = 1'b1;
            a_data = 8'(8'h50 + k);
            @(negedge clk);
            check("flush_setup_ready", a_o_ready, 1);
            next_cycle();
        end
        a_valid = 1'b0;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            a_ready = 1'b1;
            a_flush = (k == 0 || k == 2);
            @(negedge clk);
            check($sformatf("flush_k%0d_ready", k), a_o_ready, (k == 0 || k == 7));
            check($sformatf("flush_k%0d_done", k), a_fd, (k == 6));
            next_cycle();
        end
        a_flush = 1'b0;
        wait_idle("flush_idle", 1'b0, 50);
        check("flush_count", deliv_a - base, 5);

        // Reset with 4 beats in flight.
        a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1;
            a_data = 8'(8'h60 + k);
            @(negedge clk);
            check("rst_setup_ready", a_o_ready, 1);
            next_cycle();
        end
        a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_low", a_o_ready, 0);
        check("rst_launch_low", a_launch, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", a_o_valid, 0);
        check("rst_data", a_o_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_flush_done", a_fd, 0);
        check("rst_ready_after", a_o_ready, 1);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_late_valid", a_o_valid, 0);
            check("rst_late_busy", a_busy, 0);
            next_cycle();
        end

        // Randomized traffic with occasional flush pulses.
        for (int k = 0; k < 1000; k++) begin
            a_valid = ($urandom_range(0, 9) < 7);
            a_data = 8'($urandom);
            a_ready = ($urandom_range(0, 9) < 6);
            a_flush = ($urandom_range(0, 49) == 0);
            next_cycle();
        end
        a_valid = 1'b0;
        a_flush = 1'b0;
        a_ready = 1'b1;
        wait_idle("rand_idle", 1'b0, 200);
        check("rand_sb_empty", exp_a.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
